bitstream_serializer: RTL and testbench
=======================================

# bitstream_serializer

Downstream stage of `entropy_encoder`. It consumes the encoder's per-cycle bitstream bundle (up to three literal bytes, or one byte plus a run-length-coded repeated byte plus up to two tail bytes) and expands it into a plain in-order byte stream with a valid/ready handshake. A descriptor FIFO absorbs encoder bursts, because the encoder has no backpressure input. End-of-frame is signalled by `in_flag_last` and reported as a one-cycle pulse after the frame's final byte.

## Interface
- `BITSTREAM_WIDTH`, 8: byte width of every data lane and of `out_byte`.
- `DESC_DEPTH`, 8: descriptor FIFO entries (power of two, ≥2).
- `COUNT_WIDTH`, 32: width of the per-frame byte counter.

Ports:
- `top_clk`  in  1  clock; everything is rising-edge.
- `top_reset`  in  1  synchronous, active-low reset.
- `in_bit_1`..`in_bit_5`  in  8 each  encoder lanes `OUT_BIT_1`..`OUT_BIT_5`.
- `in_flag_bitstream`  in  3  encoder `OUT_FLAG_BITSTREAM`.
- `in_flag_last`  in  1  encoder `OUT_FLAG_LAST`.
- `out_byte`  out  8  current output byte.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  sink accepts the byte when `out_valid & out_ready`.
- `out_frame_done`  out  1  one-cycle pulse when a frame is fully delivered.
- `out_frame_bytes`  out  COUNT_WIDTH  byte count of the last completed frame; updated with `out_frame_done`.
- `err_overflow`  out  1  sticky; a descriptor was dropped because the FIFO was full.
- `err_flag`  out  1  sticky; `in_flag_bitstream == 4` was received.

## Operation
Descriptor decode (flag F, lanes b1..b5, run count R = `in_bit_3` taken as unsigned 8-bit):
- F=0: no bytes.
- F=1,2,3: emit b1..bF in lane order.
- F=5: emit b1, then b2 R times.
- F=6: emit b1, then b2 R times, then b4.
- F=7: emit b1, then b2 R times, then b4, then b5.
- R=0 is legal: the run is skipped.
- F=4 is illegal: the cycle's bytes are discarded and `err_flag` is set. A last-edge arriving in the same cycle is still honoured.

Last-edge detection:
- A last-edge is `in_flag_last & ~last_q`, where `last_q` is the registered previous `in_flag_last`.
- A level held high counts once.

FIFO push and full behaviour:
- A push occurs when F ∉ {0,4} or a last-edge occurs.
- Entry contents: lanes, F, last bit.
- Push when full is accepted only if a pop happens in the same cycle. Otherwise the entry is dropped and `err_overflow` is set.

Expander FSM, states IDLE, LIT, HEAD, RUN, TAIL4, TAIL5, DONE:
- IDLE: if the FIFO is non-empty, pop and load the entry and the run counter, then go to LIT (F≤3) or HEAD (F≥5).
- An entry with zero bytes and last=1 goes straight to DONE.
- LIT: emit lanes 1..F in order, advancing an index on each handshake.
- HEAD: emit b1. Next state is RUN if R>0, else TAIL4 (F≥6) or the end of the entry.
- RUN: emit b2 and decrement the counter on each handshake; leave when the counter reaches 0.
- TAIL4, then TAIL5: emitted only when F allows.
- End of entry: if last=1, go to DONE. Otherwise pop the next entry in the same cycle as the final handshake (no bubble), or go to IDLE if the FIFO is empty.
- DONE: for one cycle, pulse `out_frame_done`, load `out_frame_bytes` with the frame byte counter, and clear the counter. Then go to IDLE.
- The frame byte counter increments on every handshake and wraps modulo 2^COUNT_WIDTH.

Output handshake:
- `out_byte` and `out_valid` are registered.
- Once `out_valid` is high, `out_byte` is stable until the handshake.
- `out_valid` never drops without a handshake.

## Timing
- Reset values:
  - `out_byte` = 0, `out_valid` = 0, `out_frame_done` = 0, `out_frame_bytes` = 0.
  - Both error flags 0.
  - FIFO empty, FSM in IDLE, `last_q` = 0, counters 0.
- Reset mid-frame discards all FIFO contents and partially emitted runs immediately, with no frame-done pulse.
- Latency: with the FIFO empty, FSM in IDLE, and a descriptor sampled at edge E, the first byte has `out_valid` high after edge E+2.
- Throughput: one byte per cycle while `out_ready` = 1, including across descriptor boundaries.
- The DONE state costs exactly one cycle with `out_valid` low.
- `out_frame_done` rises after the edge that ends the final handshake +1. It is never asserted together with `out_valid` belonging to the same frame.
- Simultaneous push and pop with the FIFO full: both occur; occupancy is unchanged.

## Test plan
- **Literal bytes:** F=3, b1..b3=0x11,0x22,0x33, `out_ready` = 1.
  - Bytes 0x11,0x22,0x33 appear on consecutive cycles, the first after E+2.
- **Run with both tails:** F=7, b1=0xA0, b2=0xFF, R=4, b4=0x05, b5=0x06.
  - Output sequence 0xA0, 0xFF×4, 0x05, 0x06.
  - Then F=5 with R=0, b1=0x7E: only 0x7E, with no gap between the two descriptors.
- **Backpressure:** toggle `out_ready` 1010… during a F=6, R=3 burst.
  - Byte order is intact and `out_byte` is stable while stalled.
  - Push 9 descriptors while `out_ready` = 0: `err_overflow` = 1, and only the first 8 descriptors are emitted.
- **Frame end:** F=2 (0x01,0x02) together with `in_flag_last` held high for 3 cycles.
  - `out_frame_done` pulses once, `out_frame_bytes` = 2.
  - A last-edge with F=0 on an empty pipe gives a pulse with `out_frame_bytes` = 0.
- **Illegal flag:** F=4 with lanes non-zero.
  - No bytes emitted, `err_flag` = 1 (held until reset).
- **Mid-run reset:** assert `top_reset` = 0 for one edge during RUN with R=200.
  - All outputs return to their reset values on that edge, with no frame-done pulse.
  - The next F=1 descriptor is emitted normally.

Source files
------------

// File: rtl/bitstream_serializer.sv
// -----------------------------------------------------------------------------
// bitstream_serializer
//
// Expands the per-cycle bitstream bundle of entropy_encoder into a plain,
// in-order byte stream with a valid/ready handshake. Descriptors are buffered
// in a small FIFO because the encoder cannot be stalled. Frame ends are
// reported by a one-cycle pulse once the frame's last byte has left.
//
// Ports:
//   top_clk            clock, rising edge
//   top_reset          synchronous reset, active low
//   in_bit_1..5        encoder data lanes (in_bit_3 doubles as run count)
//   in_flag_bitstream  encoder lane-usage flag (4 is illegal)
//   in_flag_last       encoder end-of-frame level; its rising edge marks a frame end
//   out_byte           registered output byte
//   out_valid          out_byte is valid
//   out_ready          sink accepts out_byte when out_valid & out_ready
//   out_frame_done     one-cycle pulse after a frame is fully delivered
//   out_frame_bytes    byte count of the last completed frame
//   err_overflow       sticky: a descriptor was dropped on a full FIFO
//   err_flag           sticky: an illegal flag value was received
// -----------------------------------------------------------------------------
module bitstream_serializer #(
  parameter int BITSTREAM_WIDTH = 8,
  parameter int DESC_DEPTH      = 8,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                       top_clk,
  input  logic                       top_reset,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                 in_flag_bitstream,
  input  logic                       in_flag_last,
  output logic [BITSTREAM_WIDTH-1:0] out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_frame_done,
  output logic [COUNT_WIDTH-1:0]     out_frame_bytes,
  output logic                       err_overflow,
  output logic                       err_flag
);

  localparam int PTR_W = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]           FIFO_FULL = CNT_W'(DESC_DEPTH);
  localparam logic [CNT_W-1:0]           FCNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]           PTR_ONE   = PTR_W'(1);
  localparam logic [BITSTREAM_WIDTH-1:0] RUN_ONE   = BITSTREAM_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]     COUNT_ONE = COUNT_WIDTH'(1);

  typedef struct packed {
    logic [BITSTREAM_WIDTH-1:0] b1;
    logic [BITSTREAM_WIDTH-1:0] b2;
    logic [BITSTREAM_WIDTH-1:0] b3;
    logic [BITSTREAM_WIDTH-1:0] b4;
    logic [BITSTREAM_WIDTH-1:0] b5;
    logic [2:0]                 flag;
    logic                       last;
  } desc_t;

  typedef enum logic [2:0] {IDLE, LIT, HEAD, RUN, TAIL4, TAIL5, DONE} state_t;

  // Input capture and FIFO
  logic             last_q;
  logic             lastEdge, flagIllegal, hasBytes, pushReq, pushAccept, pop;
  logic             fifoEmpty, fifoFull;
  desc_t            pushDesc, headDesc;
  desc_t            fifoMem_q [DESC_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] fifoCount_q;

  // Expander
  state_t                     state_q, state_d;
  desc_t                      entry_q, entry_d;
  logic [BITSTREAM_WIDTH-1:0] runCnt_q, runCnt_d;
  logic [1:0]                 litIdx_q, litIdx_d;
  logic [BITSTREAM_WIDTH-1:0] outByte_q, outByte_d, curByte, litByte;
  logic                       outValid_q, outValid_d;
  logic                       frameDone_q, frameDone_d;
  logic [COUNT_WIDTH-1:0]     frameBytes_q, frameBytes_d;
  logic [COUNT_WIDTH-1:0]     frameCount_q, frameCount_d;
  logic                       errOverflow_q, errFlag_q;
  logic                       advance, emit, endOfEntry, takeNext;

  function automatic state_t startState(input logic [2:0] f);
    // Zero-byte entries only exist as bare frame ends.
    if (f == 3'd0)  return DONE;
    else if (f[2])  return HEAD;
    else            return LIT;
  endfunction

  // An illegal flag drops the bytes but a coincident last-edge still becomes
  // an (empty) entry so the frame end is not lost.
  always_comb begin
    lastEdge    = in_flag_last & ~last_q;
    flagIllegal = (in_flag_bitstream == 3'd4);
    hasBytes    = (in_flag_bitstream != 3'd0) && !flagIllegal;
    pushReq     = hasBytes | lastEdge;
    fifoEmpty   = (fifoCount_q == '0);
    fifoFull    = (fifoCount_q == FIFO_FULL);
    pushAccept  = pushReq & (~fifoFull | pop);
    pushDesc.b1   = in_bit_1;
    pushDesc.b2   = in_bit_2;
    pushDesc.b3   = in_bit_3;
    pushDesc.b4   = in_bit_4;
    pushDesc.b5   = in_bit_5;
    pushDesc.flag = hasBytes ? in_flag_bitstream : 3'd0;
    pushDesc.last = lastEdge;
    headDesc      = fifoMem_q[rdPtr_q];
  end

  // Descriptor storage needs no reset; the pointers define what is valid.
  always_ff @(posedge top_clk) begin
    if (top_reset && pushAccept) begin
      fifoMem_q[wrPtr_q] <= pushDesc;
    end
  end

  always_ff @(posedge top_clk) begin
    if (!top_reset) begin
      last_q        <= 1'b0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      fifoCount_q   <= '0;
      errOverflow_q <= 1'b0;
      errFlag_q     <= 1'b0;
    end else begin
      last_q <= in_flag_last;
      if (pushAccept) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop)        rdPtr_q <= rdPtr_q + PTR_ONE;
      case ({pushAccept, pop})
        2'b10:   fifoCount_q <= fifoCount_q + FCNT_ONE;
        2'b01:   fifoCount_q <= fifoCount_q - FCNT_ONE;
        default: fifoCount_q <= fifoCount_q;
      endcase
      if (pushReq && fifoFull && !pop) errOverflow_q <= 1'b1;
      if (flagIllegal)                 errFlag_q     <= 1'b1;
    end
  end

  // The state names the byte to be loaded next into the output register; a
  // load happens whenever that register is empty or being consumed, so the
  // last byte of one entry and the first of the next go out back to back.
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    runCnt_d     = runCnt_q;
    litIdx_d     = litIdx_q;
    outByte_d    = outByte_q;
    outValid_d   = outValid_q & ~out_ready;
    frameDone_d  = 1'b0;
    frameBytes_d = frameBytes_q;
    frameCount_d = frameCount_q + ((outValid_q && out_ready) ? COUNT_ONE : '0);
    pop          = 1'b0;
    emit         = 1'b0;
    endOfEntry   = 1'b0;
    takeNext     = 1'b0;
    curByte      = '0;
    advance      = ~outValid_q | out_ready;

    case (litIdx_q)
      2'd0:    litByte = entry_q.b1;
      2'd1:    litByte = entry_q.b2;
      default: litByte = entry_q.b3;
    endcase

    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) takeNext = 1'b1;
      end
      LIT: begin
        curByte = litByte;
        if (advance) begin
          emit = 1'b1;
          if ({1'b0, litIdx_q} == entry_q.flag - 3'd1) endOfEntry = 1'b1;
          else                                         litIdx_d   = litIdx_q + 2'd1;
        end
      end
      HEAD: begin
        curByte = entry_q.b1;
        if (advance) begin
          emit = 1'b1;
          if (runCnt_q != '0)       state_d    = RUN;
          else if (entry_q.flag[1]) state_d    = TAIL4;
          else                      endOfEntry = 1'b1;
        end
      end
      RUN: begin
        curByte = entry_q.b2;
        if (advance) begin
          emit     = 1'b1;
          runCnt_d = runCnt_q - RUN_ONE;
          if (runCnt_q == RUN_ONE) begin
            if (entry_q.flag[1]) state_d    = TAIL4;
            else                 endOfEntry = 1'b1;
          end
        end
      end
      TAIL4: begin
        curByte = entry_q.b4;
        if (advance) begin
          emit = 1'b1;
          if (entry_q.flag[0]) state_d    = TAIL5;
          else                 endOfEntry = 1'b1;
        end
      end
      TAIL5: begin
        curByte = entry_q.b5;
        if (advance) begin
          emit       = 1'b1;
          endOfEntry = 1'b1;
        end
      end
      DONE: begin
        // Wait for the frame's last byte to leave so the count is complete.
        if (!outValid_q) begin
          frameDone_d  = 1'b1;
          frameBytes_d = frameCount_q;
          frameCount_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      outValid_d = 1'b1;
      outByte_d  = curByte;
    end

    if (endOfEntry) begin
      if (entry_q.last)    state_d  = DONE;
      else if (!fifoEmpty) takeNext = 1'b1;
      else                 state_d  = IDLE;
    end

    if (takeNext) begin
      pop      = 1'b1;
      entry_d  = headDesc;
      runCnt_d = headDesc.b3;
      litIdx_d = 2'd0;
      state_d  = startState(headDesc.flag);
    end
  end

  always_ff @(posedge top_clk) begin
    if (!top_reset) begin
      state_q      <= IDLE;
      entry_q      <= '0;
      runCnt_q     <= '0;
      litIdx_q     <= 2'd0;
      outByte_q    <= '0;
      outValid_q   <= 1'b0;
      frameDone_q  <= 1'b0;
      frameBytes_q <= '0;
      frameCount_q <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      runCnt_q     <= runCnt_d;
      litIdx_q     <= litIdx_d;
      outByte_q    <= outByte_d;
      outValid_q   <= outValid_d;
      frameDone_q  <= frameDone_d;
      frameBytes_q <= frameBytes_d;
      frameCount_q <= frameCount_d;
    end
  end

  assign out_byte        = outByte_q;
  assign out_valid       = outValid_q;
  assign out_frame_done  = frameDone_q;
  assign out_frame_bytes = frameBytes_q;
  assign err_overflow    = errOverflow_q;
  assign err_flag        = errFlag_q;

endmodule

// File: tb/tb_bitstream_serializer.sv
// -----------------------------------------------------------------------------
// tb_bitstream_serializer
//
// Directed bench for bitstream_serializer. Stimulus tasks queue the
// hand-computed bytes and frame counts; an independent monitor pops them as
// the DUT hands bytes over or pulses frame-done.
// -----------------------------------------------------------------------------
module tb_bitstream_serializer;

  logic        top_clk = 1'b0;
  logic        top_reset;
  logic [7:0]  in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
  logic [2:0]  in_flag_bitstream;
  logic        in_flag_last;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_frame_done;
  logic [31:0] out_frame_bytes;
  logic        err_overflow;
  logic        err_flag;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  expByteQ [$];
  logic [31:0] expDoneQ [$];
  bit          inReset  = 1'b1;
  bit          stallPrev = 1'b0;
  logic [7:0]  prevByte = 8'h00;

  always #5 top_clk = ~top_clk;

  bitstream_serializer #(
    .BITSTREAM_WIDTH(8),
    .DESC_DEPTH     (8),
    .COUNT_WIDTH    (32)
  ) dut (
    .top_clk          (top_clk),
    .top_reset        (top_reset),
    .in_bit_1         (in_bit_1),
    .in_bit_2         (in_bit_2),
    .in_bit_3         (in_bit_3),
    .in_bit_4         (in_bit_4),
    .in_bit_5         (in_bit_5),
    .in_flag_bitstream(in_flag_bitstream),
    .in_flag_last     (in_flag_last),
    .out_byte         (out_byte),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_frame_done   (out_frame_done),
    .out_frame_bytes  (out_frame_bytes),
    .err_overflow     (err_overflow),
    .err_flag         (err_flag)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one descriptor for exactly one clock edge, then idles the lanes.
  task automatic applyStimulus(input logic [2:0] f, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                               input logic last);
    in_flag_bitstream = f;
    in_bit_1 = b1; in_bit_2 = b2; in_bit_3 = b3; in_bit_4 = b4; in_bit_5 = b5;
    in_flag_last = last;
    @(negedge top_clk);
    in_flag_bitstream = 3'd0;
    in_bit_1 = 8'h00; in_bit_2 = 8'h00; in_bit_3 = 8'h00; in_bit_4 = 8'h00; in_bit_5 = 8'h00;
    in_flag_last = 1'b0;
  endtask

  task automatic expectByte(input logic [7:0] b);
    expByteQ.push_back(b);
  endtask

  task automatic expectRun(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) expByteQ.push_back(b);
  endtask

  task automatic resetDut();
    @(negedge top_clk);
    top_reset = 1'b0;
    inReset   = 1'b1;
    @(negedge top_clk);
    top_reset = 1'b1;
    expByteQ.delete();
    expDoneQ.delete();
    inReset   = 1'b0;
    checkOutput("rstValid",      32'(out_valid),       32'd0);
    checkOutput("rstByte",       32'(out_byte),        32'd0);
    checkOutput("rstDone",       32'(out_frame_done),  32'd0);
    checkOutput("rstFrameBytes", out_frame_bytes,      32'd0);
    checkOutput("rstOverflow",   32'(err_overflow),    32'd0);
    checkOutput("rstErrFlag",    32'(err_flag),        32'd0);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expByteQ.size() != 0 || expDoneQ.size() != 0) && n < budget) begin
      @(negedge top_clk);
      n++;
    end
    repeat (4) @(negedge top_clk);
    checkOutput("drain", 32'(expByteQ.size() + expDoneQ.size()), 32'd0);
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    forever begin
      @(negedge top_clk);
      #4;
      if (inReset) begin
        stallPrev = 1'b0;
      end else begin
        if (stallPrev) begin
          checkOutput("holdValid", 32'(out_valid), 32'd1);
          checkOutput("holdByte",  32'(out_byte),  32'(prevByte));
        end
        if (out_valid && out_ready) begin
          if (expByteQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL extraByte: got 0x%0h, wanted no byte at %0t", out_byte, $time);
          end else begin
            checkOutput("byte", 32'(out_byte), 32'(expByteQ.pop_front()));
          end
        end
        if (out_frame_done) begin
          checkOutput("doneWithValid", 32'(out_valid), 32'd0);
          if (expDoneQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL extraDone: got pulse bytes=%0d, wanted no pulse at %0t", out_frame_bytes, $time);
          end else begin
            checkOutput("frameBytes", out_frame_bytes, expDoneQ.pop_front());
          end
        end
        stallPrev = out_valid && !out_ready;
        prevByte  = out_byte;
      end
    end
  end

  initial begin
    #400000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    top_reset = 1'b0;
    in_flag_bitstream = 3'd0;
    in_bit_1 = 8'h00; in_bit_2 = 8'h00; in_bit_3 = 8'h00; in_bit_4 = 8'h00; in_bit_5 = 8'h00;
    in_flag_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge top_clk);
    top_reset = 1'b1;
    inReset   = 1'b0;
    checkOutput("rstValid",      32'(out_valid),      32'd0);
    checkOutput("rstByte",       32'(out_byte),       32'd0);
    checkOutput("rstDone",       32'(out_frame_done), 32'd0);
    checkOutput("rstFrameBytes", out_frame_bytes,     32'd0);
    checkOutput("rstOverflow",   32'(err_overflow),   32'd0);
    checkOutput("rstErrFlag",    32'(err_flag),       32'd0);

    $display("[TB] literal bytes");
    out_ready = 1'b1;
    expectByte(8'h11); expectByte(8'h22); expectByte(8'h33);
    applyStimulus(3'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 1'b0);
    checkOutput("latE0", 32'(out_valid), 32'd0);
    @(negedge top_clk);
    checkOutput("latE1", 32'(out_valid), 32'd0);
    @(negedge top_clk);
    checkOutput("latE2", 32'(out_valid), 32'd1);
    checkOutput("firstByte", 32'(out_byte), 32'h11);
    waitDrain(20);

    $display("[TB] run with tails, then empty run");
    expectByte(8'hA0); expectRun(8'hFF, 4); expectByte(8'h05); expectByte(8'h06);
    expectByte(8'h7E);
    applyStimulus(3'd7, 8'hA0, 8'hFF, 8'd4, 8'h05, 8'h06, 1'b0);
    applyStimulus(3'd5, 8'h7E, 8'h99, 8'd0, 8'h00, 8'h00, 1'b0);
    begin
      int w = 0;
      while (!out_valid && w < 20) begin
        @(negedge top_clk);
        w++;
      end
      for (int i = 0; i < 8; i++) begin
        checkOutput("noGap", 32'(out_valid), 32'd1);
        @(negedge top_clk);
      end
    end
    waitDrain(20);

    $display("[TB] backpressure toggle");
    expectByte(8'h31); expectRun(8'h32, 3); expectByte(8'h34);
    applyStimulus(3'd6, 8'h31, 8'h32, 8'd3, 8'h34, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge top_clk);
    end
    out_ready = 1'b1;
    waitDrain(20);

    $display("[TB] overflow");
    out_ready = 1'b0;
    expectByte(8'h41); expectByte(8'h42); expectByte(8'h43);
    applyStimulus(3'd3, 8'h41, 8'h42, 8'h43, 8'h00, 8'h00, 1'b0);
    repeat (4) @(negedge top_clk);
    for (int i = 0; i < 8; i++) begin
      expectByte(8'(8'h50 + i));
      applyStimulus(3'd1, 8'(8'h50 + i), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    checkOutput("ovfAtFull", 32'(err_overflow), 32'd0);
    applyStimulus(3'd1, 8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("ovfDropped", 32'(err_overflow), 32'd1);
    repeat (3) @(negedge top_clk);
    out_ready = 1'b1;
    waitDrain(40);
    checkOutput("ovfSticky", 32'(err_overflow), 32'd1);

    $display("[TB] frame end");
    resetDut();
    out_ready = 1'b1;
    expectByte(8'h01); expectByte(8'h02);
    expDoneQ.push_back(32'd2);
    in_flag_bitstream = 3'd2; in_bit_1 = 8'h01; in_bit_2 = 8'h02; in_flag_last = 1'b1;
    @(negedge top_clk);
    in_flag_bitstream = 3'd0; in_bit_1 = 8'h00; in_bit_2 = 8'h00;
    repeat (2) @(negedge top_clk);
    in_flag_last = 1'b0;
    waitDrain(20);
    expDoneQ.push_back(32'd0);
    applyStimulus(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    waitDrain(20);

    $display("[TB] illegal flag");
    checkOutput("errFlagClear", 32'(err_flag), 32'd0);
    applyStimulus(3'd4, 8'hAA, 8'hBB, 8'h03, 8'hCC, 8'hDD, 1'b0);
    repeat (6) @(negedge top_clk);
    checkOutput("errFlagSet", 32'(err_flag), 32'd1);
    expDoneQ.push_back(32'd0);
    applyStimulus(3'd4, 8'h12, 8'h34, 8'h05, 8'h56, 8'h78, 1'b1);
    waitDrain(20);
    checkOutput("errFlagHeld", 32'(err_flag), 32'd1);
    checkOutput("noOverflow",  32'(err_overflow), 32'd0);

    $display("[TB] mid-run reset");
    expectByte(8'h10); expectRun(8'h20, 200);
    applyStimulus(3'd5, 8'h10, 8'h20, 8'd200, 8'h00, 8'h00, 1'b0);
    repeat (10) @(negedge top_clk);
    resetDut();
    repeat (4) @(negedge top_clk);
    checkOutput("postRstValid", 32'(out_valid), 32'd0);
    expectByte(8'h5A);
    expDoneQ.push_back(32'd1);
    applyStimulus(3'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    waitDrain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
